// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops, iterative shifts,
// shift-add multiply, Z/C/N/V flags and a start/busy/done handshake.
module alu_mc #(
  parameter int unsigned W    = 8,
  parameter int unsigned BUSW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [6:0]      alus,
  input  logic [W-1:0]    ac,
  input  logic [BUSW-1:0] bus,
  output logic [W-1:0]    dout,
  output logic [W-1:0]    dout_hi,
  output logic [3:0]      flags,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [6:0] OP_ADD = 7'd1;
  localparam logic [6:0] OP_SUB = 7'd2;
  localparam logic [6:0] OP_AND = 7'd3;
  localparam logic [6:0] OP_OR  = 7'd4;
  localparam logic [6:0] OP_XOR = 7'd5;
  localparam logic [6:0] OP_INC = 7'd6;
  localparam logic [6:0] OP_CLR = 7'd7;
  localparam logic [6:0] OP_NOT = 7'd8;
  localparam logic [6:0] OP_PAS = 7'd9;
  localparam logic [6:0] OP_SHL = 7'd10;
  localparam logic [6:0] OP_SHR = 7'd11;
  localparam logic [6:0] OP_ASR = 7'd12;
  localparam logic [6:0] OP_MUL = 7'd13;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t        r_state;
  logic [6:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_hi;
  logic          r_c;
  logic [CW-1:0] r_cnt;

  logic [CW-1:0]  w_n_in;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_sh_a;
  logic           w_sh_c;
  logic [W-1:0]   w_lo;
  logic [W-1:0]   w_hi;
  logic           w_fc;
  logic           w_fv;
  logic           w_fz;
  logic           w_fn;
  logic           w_illegal;
  logic           w_unused;

  assign w_unused  = ^bus;
  assign w_n_in    = CW'(bus[W-1:0] % W);
  assign w_illegal = (r_op == 7'd0) || (r_op > OP_MUL);

  // One multiplier bit per step: add A into the high half, shift product right.
  assign w_sum  = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : (W+1)'(0));
  assign w_prod = {w_sum, r_b[W-1:1]};

  // One-bit shift step; carry captures the bit leaving the register.
  always_comb begin
    w_sh_a = r_a;
    w_sh_c = r_c;
    case (r_op)
      OP_SHL: begin w_sh_a = {r_a[W-2:0], 1'b0};    w_sh_c = r_a[W-1]; end
      OP_SHR: begin w_sh_a = {1'b0, r_a[W-1:1]};    w_sh_c = r_a[0];   end
      OP_ASR: begin w_sh_a = {r_a[W-1], r_a[W-1:1]}; w_sh_c = r_a[0];  end
      default: ;
    endcase
  end

  // Result and flags presented on the final EXEC cycle.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_fc = 1'b0;
    w_fv = 1'b0;
    case (r_op)
      OP_ADD: begin
        {w_fc, w_lo} = {1'b0, r_a} + {1'b0, r_b};
        w_fv = (r_a[W-1] == r_b[W-1]) && (w_lo[W-1] != r_a[W-1]);
      end
      OP_SUB: begin
        w_lo = r_a - r_b;
        w_fc = r_a < r_b;
        w_fv = (r_a[W-1] != r_b[W-1]) && (w_lo[W-1] != r_a[W-1]);
      end
      OP_AND: w_lo = r_a & r_b;
      OP_OR:  w_lo = r_a | r_b;
      OP_XOR: w_lo = r_a ^ r_b;
      OP_INC: {w_fc, w_lo} = {1'b0, r_a} + (W+1)'(1);
      OP_CLR: w_lo = '0;
      OP_NOT: w_lo = ~r_a;
      OP_PAS: w_lo = r_b;
      OP_SHL, OP_SHR, OP_ASR: begin
        w_lo = r_a;
        w_fc = r_c;
      end
      OP_MUL: begin
        {w_hi, w_lo} = w_prod;
        w_fc = |w_prod[2*W-1:W];
      end
      default: ;
    endcase
    w_fz = (w_lo == '0) && (w_hi == '0);
    w_fn = (r_op == OP_MUL) ? w_hi[W-1] : w_lo[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      dout    <= '0;
      dout_hi <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= alus;
            r_a   <= ac;
            r_b   <= bus[W-1:0];
            r_hi  <= '0;
            r_c   <= 1'b0;
            // Extra EXEC cycles beyond the first: n for shifts, W-1 for MUL.
            if (alus == OP_MUL)
              r_cnt <= CW'(W - 1);
            else if (alus == OP_SHL || alus == OP_SHR || alus == OP_ASR)
              r_cnt <= w_n_in;
            else
              r_cnt <= '0;
            busy    <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            dout    <= w_lo;
            dout_hi <= w_hi;
            if (w_illegal)
              err <= 1'b1;
            else
              flags <= {w_fz, w_fc, w_fn, w_fv};
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op == OP_MUL)
              {r_hi, r_b} <= w_prod;
            else begin
              r_a <= w_sh_a;
              r_c <= w_sh_c;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops
// compared against an integer-arithmetic reference model.
module tb_alu_mc;

  localparam int unsigned W    = 8;
  localparam int unsigned BUSW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [6:0]      alus;
  logic [W-1:0]    ac;
  logic [BUSW-1:0] bus;
  logic [W-1:0]    dout;
  logic [W-1:0]    dout_hi;
  logic [3:0]      flags;
  logic            busy;
  logic            done;
  logic            err;

  alu_mc #(.W(W), .BUSW(BUSW)) dut (
    .clk(clk), .rst(rst), .start(start), .alus(alus), .ac(ac), .bus(bus),
    .dout(dout), .dout_hi(dout_hi), .flags(flags), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model outputs; exp_flags persists across ops like the flag register.
  int         m_lo, m_hi, m_err, m_lat;
  logic [3:0] exp_flags;

  function automatic void model(input int op, input int a, input int b);
    int mod, sa, sb, s, sr, n, c, v, z, ng;
    longint p;
    mod = 1 << W;
    a = a % mod; b = b % mod;
    sa = (a >= mod / 2) ? a - mod : a;
    sb = (b >= mod / 2) ? b - mod : b;
    n = b % W;
    m_lo = 0; m_hi = 0; m_err = 0; m_lat = 2; c = 0; v = 0;
    case (op)
      1: begin s = a + b; m_lo = s % mod; c = int'(s >= mod);
               sr = sa + sb; v = int'(sr >= mod / 2 || sr < -mod / 2); end
      2: begin s = a - b; m_lo = (s + mod) % mod; c = int'(a < b);
               sr = sa - sb; v = int'(sr >= mod / 2 || sr < -mod / 2); end
      3: m_lo = a & b;
      4: m_lo = a | b;
      5: m_lo = a ^ b;
      6: begin s = a + 1; m_lo = s % mod; c = int'(s >= mod); end
      7: m_lo = 0;
      8: m_lo = (~a) & (mod - 1);
      9: m_lo = b;
      10: begin m_lo = (a << n) % mod; c = (n != 0) ? (a >> (W - n)) & 1 : 0; m_lat = 2 + n; end
      11: begin m_lo = a >> n; c = (n != 0) ? (a >> (n - 1)) & 1 : 0; m_lat = 2 + n; end
      12: begin m_lo = (sa >>> n) & (mod - 1); c = (n != 0) ? (a >> (n - 1)) & 1 : 0; m_lat = 2 + n; end
      13: begin p = longint'(a) * longint'(b); m_lo = int'(p % mod); m_hi = int'(p / mod);
                c = int'(m_hi != 0); m_lat = W + 1; end
      default: m_err = 1;
    endcase
    z  = int'(m_lo == 0 && m_hi == 0);
    ng = (op == 13) ? (m_hi >> (W - 1)) & 1 : (m_lo >> (W - 1)) & 1;
    if (m_err == 0) exp_flags = {z[0], c[0], ng[0], v[0]};
  endfunction

  // Issue one op, optionally pulse a junk start while busy, scramble inputs, check result.
  task automatic run_op(input int op, input int a, input int b, input bit poke);
    int  edges;
    bit  seen;
    model(op, a, b);
    @(negedge clk);
    start = 1'b1; alus = 7'(op); ac = W'(a); bus = BUSW'(b);
    @(posedge clk);
    @(negedge clk);
    start = poke; alus = 7'd1; ac = W'($urandom); bus = BUSW'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    edges = 0; seen = 1'b0;
    while (!seen && edges < 4 * W + 8) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("done_timeout", 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("dout op%0d", op), 32'(dout), 32'(m_lo));
      check($sformatf("dout_hi op%0d", op), 32'(dout_hi), 32'(m_hi));
      check($sformatf("flags op%0d", op), 32'(flags), 32'(exp_flags));
      check($sformatf("err op%0d", op), 32'(err), 32'(m_err));
      check($sformatf("latency op%0d", op), 32'(edges + 1), 32'(m_lat));
      check("busy_at_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int  ops [15];
    logic [8:0] mask;
    bit  seen;
    rst = 1'b1; start = 1'b0; alus = '0; ac = '0; bus = '0;
    exp_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({dout, dout_hi, flags, busy, done, err}), 32'd0);

    // Reset in the middle of a multiply: outputs clear, no done follows.
    @(negedge clk); rst = 1'b0; start = 1'b1; alus = 7'd13; ac = 8'hFF; bus = 16'h00FF;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_mul_reset", 32'({dout, dout_hi, flags, busy, done, err}), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("no_done_after_reset", 32'(seen), 32'd0);
    exp_flags = '0;
    run_op(1, 8'h01, 8'h02, 1'b0);

    // Reset and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; alus = 7'd1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_beats_start", 32'({busy, done}), 32'd0);
    exp_flags = '0;

    run_op(1, 8'h7F, 8'h01, 1'b0);
    run_op(1, 8'hFF, 8'h01, 1'b0);
    run_op(0, 8'h12, 8'h34, 1'b0);
    run_op(2, 8'h03, 8'h05, 1'b0);
    run_op(7'h7F, 8'h55, 8'h01, 1'b0);
    run_op(10, 8'h81, 8'h01, 1'b0);
    run_op(12, 8'h80, 8'h03, 1'b0);
    run_op(11, 8'hA5, 8'h08, 1'b0);
    run_op(13, 8'hFF, 8'hFF, 1'b1);
    run_op(13, 8'h00, 8'h37, 1'b1);

    // Start held high with INC: one acceptance every three cycles.
    @(negedge clk); start = 1'b1; alus = 7'd6; ac = 8'h10; bus = '0;
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      mask[i] = done;
      if (done) check("held_inc_dout", 32'(dout), 32'h11);
    end
    check("held_start_pattern", 32'(mask), 32'b010010010);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    exp_flags = '0;

    ops = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 0, 14};
    for (int i = 0; i < 80; i++)
      run_op(ops[$urandom_range(0, 14)], int'($urandom_range(0, 255)),
             int'($urandom_range(0, 65535)), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, registered, multi-cycle arithmetic logic unit. It replaces the purely combinational datapath ALU in the CPU core. Single-cycle operations keep the existing `alus` codes 1–9. It adds iterative shifts and a shift-add multiply, a flag register (Z/C/N/V), and a start/busy/done handshake so the control unit can stall on long operations.

## Interface
Parameters:
- `W`, 8, datapath width of `ac`, operand B and result.
- `BUSW`, 16, width of `bus`; must be ≥ `W`. Operand B is `bus[W-1:0]`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `alus`  in  7  operation code; sampled with `start`.
- `ac`  in  W  operand A; sampled with `start`.
- `bus`  in  BUSW  operand B source; sampled with `start`.
- `dout`  out  W  result (low half for MUL); registered.
- `dout_hi`  out  W  high half of MUL product; 0 for all other ops.
- `flags`  out  4  {Z,C,N,V}; registered.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `dout`/`dout_hi`/`flags` valid from this cycle and held until the next `done`.
- `err`  out  1  pulses with `done` on an illegal `alus`.

## Operation
- Operand latching: on `start` in IDLE, capture A=`ac`, B=`bus[W-1:0]` and op. Inputs may change afterwards.
- Single-cycle ops (result mod 2^W):
  - 1 ADD A+B
  - 2 SUB A−B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 INC A+1
  - 7 CLR 0
  - 8 NOT ~A
  - 9 PASS B
- Iterative ops:
  - 10 SHL: A << n, n = B mod W, one bit per cycle, zero fill.
  - 11 SHR: logical A >> n, same rules.
  - 12 ASR: arithmetic shift right, MSB replicated.
  - 13 MUL: unsigned A×B, 2W-bit product, shift-add, one multiplier bit per cycle, exactly W iterations.
- Illegal op (0, ≥14):
  - `dout` = 0, `dout_hi` = 0, flags unchanged, `err`=1 with `done`.
- Flags, updated only at `done`:
  - Z: result (low W bits; for MUL the full 2W product) == 0.
  - N: result MSB (MUL: product bit 2W−1).
  - C:
    - ADD: carry-out.
    - SUB: borrow (A<B unsigned).
    - INC: carry-out.
    - Shifts: last bit shifted out, 0 if n=0.
    - MUL: `dout_hi`≠0.
    - Others: 0.
  - V:
    - ADD/SUB: two's-complement overflow.
    - Others: 0.
- FSM states and transitions:
  - IDLE → EXEC on `start`.
  - EXEC iterates until count exhausted → DONE.
  - DONE → IDLE unconditionally.
  - Single-cycle ops pass through EXEC for exactly one cycle.
- `start` asserted while not IDLE (including DONE) is ignored; no queueing.

## Timing
- Reset values: `dout`=0, `dout_hi`=0, `flags`=0, `busy`=0, `done`=0, `err`=0, state=IDLE, counters/operand registers cleared.
- Reset mid-operation: operation is aborted and all outputs take reset values on the next edge. No `done` is produced for the aborted op.
- Latency, from the cycle with `start` sampled (edge k) to `done`:
  - Single-cycle ops and illegal ops: `done` high in cycle k+2. `busy` high in cycle k+1 only.
  - Shifts: `done` at k+2+n. n=0 behaves as a single-cycle op.
  - MUL: `done` at k+2+(W−1), i.e. W EXEC cycles.
- `rst` and `start` in the same cycle: `rst` wins.
- Back-to-back operation: earliest next accepted `start` is the cycle after `done`. Throughput for single-cycle ops is one op per 3 cycles.
- Outputs are register-driven only; no combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert `rst` 2 cycles mid-MUL (A=0xFF, B=0xFF) → all outputs 0, no `done`. A following ADD 0x01+0x02 → `dout`=0x03, flags=0000.
- Arithmetic flags (W=8):
  - ADD 0x7F+0x01 → 0x80, N=1, V=1, C=0.
  - ADD 0xFF+0x01 → 0x00, Z=1, C=1.
  - SUB 0x03−0x05 → 0xFE, C=1, N=1.
- Shifts:
  - SHL 0x81 by 1 → 0x02, C=1, `done` 3 cycles after `start`.
  - ASR 0x80 by 3 → 0xF0, C=0, `done` 5 cycles after `start`.
  - SHR by B=0x08 (n=0) → `dout`=A, 2-cycle latency.
- Multiply: 0xFF×0xFF → `dout_hi`=0xFE, `dout`=0x01, C=1, `done` exactly W+1 cycles after `start`. 0x00×0x37 → product 0, Z=1.
- Handshake: hold `start` high continuously with ops 6,6,6 → ops accepted only in IDLE, one per 3 cycles. `start` pulsed during `busy` is ignored. Changing `ac` during MUL does not affect the result.
- Illegal op: `alus`=0 and `alus`=0x7F → `err` and `done` pulse together, `dout`=0, flags retain the prior value.
